// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SD-card SPI bus arbiter.
package spi_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_OWNED = 2'd2
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;
endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection: fixed priority or round-robin after last_owner.
module arb_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_masked_i,
  input  logic [IW-1:0] last_owner_i,
  input  logic          mode_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          win_vld_o
);
  always_comb begin
    int   base;
    int   idx;
    logic found;
    base      = (mode_i == ARB_RR) ? int'(last_owner_i) + 1 : 0;
    idx       = 0;
    found     = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (!found && req_masked_i[idx]) begin
        found         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = IW'(idx);
      end
    end
    win_vld_o = found;
  end
endmodule

// File: rtl/spi_bus_arbiter.sv
// N-master arbiter for the shared SD-card SPI bus with idle guard gap and
// optional hold timeout. Owner's CS/MOSI/SCLK are registered onto the pins.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   N_MASTERS    = 4,
  parameter int   ARB_MODE     = 1,
  parameter int   GUARD_CYCLES = 8,
  parameter int   MAX_HOLD     = 0,
  parameter logic CPOL         = 1'b0
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         req,
  input  logic [N_MASTERS-1:0]         m_cs,
  input  logic [N_MASTERS-1:0]         m_mosi,
  input  logic [N_MASTERS-1:0]         m_sclk,
  output logic [N_MASTERS-1:0]         grant,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         busy,
  output logic                         timeout_err,
  input  logic                         MISO,
  output logic                         m_miso,
  output logic                         CS,
  output logic                         MOSI,
  output logic                         spi_clk
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic          MODE      = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        winner_q, winner_d, last_q, last_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [N_MASTERS-1:0] lock_q, lock_d, grant_q, grant_d;
  logic                 busy_q, busy_d, to_q, to_d;
  logic                 cs_q, cs_d, mosi_q, mosi_d, sclk_q, sclk_d;

  logic [N_MASTERS-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;

  arb_rr_picker #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req_masked_i (req & ~lock_q),
    .last_owner_i (last_q),
    .mode_i       (MODE),
    .win_oh_o     (pick_oh),
    .win_idx_o    (pick_idx),
    .win_vld_o    (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    guard_d  = guard_q;
    hold_d   = hold_q;
    lock_d   = lock_q & req;
    to_d     = 1'b0;
    cs_d     = CS_IDLE;
    mosi_d   = MOSI_IDLE;
    sclk_d   = CPOL;
    unique case (state_q)
      ST_IDLE: begin
        // Counting GUARD down from GUARD_CYCLES puts the grant GUARD_CYCLES+1
        // edges after the sampling edge.
        if (pick_vld) begin
          winner_d = pick_idx;
          guard_d  = GW'(GUARD_CYCLES);
          state_d  = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (!req[winner_q]) state_d = ST_IDLE;
        else if (guard_q == '0) begin
          state_d = ST_OWNED;
          hold_d  = '0;
        end else guard_d = guard_q - 1'b1;
      end
      ST_OWNED: begin
        if (!req[winner_q]) begin
          state_d = ST_IDLE;
          last_d  = winner_q;
        end else if (MAX_HOLD > 0 && hold_q == HOLD_LAST) begin
          state_d          = ST_IDLE;
          last_d           = winner_q;
          to_d             = 1'b1;
          lock_d[winner_q] = 1'b1;
        end else begin
          cs_d   = m_cs[winner_q];
          mosi_d = m_mosi[winner_q];
          sclk_d = m_sclk[winner_q];
          if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_OWNED);
    grant_d = busy_d ? (N_MASTERS'(1) << winner_d) : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      last_q   <= IW'(N_MASTERS - 1);
      guard_q  <= '0;
      hold_q   <= '0;
      lock_q   <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      cs_q     <= CS_IDLE;
      mosi_q   <= MOSI_IDLE;
      sclk_q   <= CPOL;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      guard_q  <= guard_d;
      hold_q   <= hold_d;
      lock_q   <= lock_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = winner_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;
  assign m_miso      = MISO;
  assign CS          = cs_q;
  assign MOSI        = mosi_q;
  assign spi_clk     = sclk_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench: round-robin/timeout instance A, fixed-priority instance B.
module tb_spi_bus_arbiter;
  localparam int N = 4;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_a, req_b, m_cs, m_mosi, m_sclk;
  logic         miso;
  logic [N-1:0] grant_a, grant_b;
  logic [1:0]   gidx_a, gidx_b;
  logic         busy_a, busy_b, to_a, to_b, mmiso_a, mmiso_b;
  logic         cs_a, cs_b, mosi_a, mosi_b, sclk_a, sclk_b;

  spi_bus_arbiter #(.N_MASTERS(N), .ARB_MODE(1), .GUARD_CYCLES(8), .MAX_HOLD(100), .CPOL(1'b0)) u_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req_a), .m_cs(m_cs), .m_mosi(m_mosi), .m_sclk(m_sclk),
    .grant(grant_a), .grant_idx(gidx_a), .busy(busy_a), .timeout_err(to_a), .MISO(miso),
    .m_miso(mmiso_a), .CS(cs_a), .MOSI(mosi_a), .spi_clk(sclk_a));

  spi_bus_arbiter #(.N_MASTERS(N), .ARB_MODE(0), .GUARD_CYCLES(8), .MAX_HOLD(0), .CPOL(1'b0)) u_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req_b), .m_cs(m_cs), .m_mosi(m_mosi), .m_sclk(m_sclk),
    .grant(grant_b), .grant_idx(gidx_b), .busy(busy_b), .timeout_err(to_b), .MISO(miso),
    .m_miso(mmiso_b), .CS(cs_b), .MOSI(mosi_b), .spi_clk(sclk_b));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [N-1:0] g;
    int           at;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           cyc = 0, total = 0, bad = 0;
  int           fall_cyc = -1, to_cnt = 0;
  logic [N-1:0] prev_a = '0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    oh2i = 0;
    for (int i = 0; i < N; i++) if (v[i]) oh2i = i;
  endfunction

  always @(negedge sys_clk) begin
    if (to_a === 1'b1) to_cnt++;
    if (grant_a != '0 && prev_a == '0) begin
      if (sb.size() == 0) chk("sb_unexp", 32'(grant_a), 0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_grant", 32'(grant_a), 32'(mon_e.g));
        chk("sb_at", cyc, mon_e.at);
        chk("sb_idx", 32'(gidx_a), oh2i(mon_e.g));
        chk("sb_busy", 32'(busy_a), 1);
        if (fall_cyc >= 0) chk("gap_ok", 32'((cyc - fall_cyc) >= 9), 1);
      end
    end
    if (grant_a == '0 && prev_a != '0) fall_cyc = cyc;
    prev_a = grant_a;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_gnt(input bit b, output int at);
    int k;
    k = 0;
    while (((b ? grant_b : grant_a) == '0) && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    if (k >= 300) chk("gnt_wait", 0, 1);
    at = cyc;
  endtask

  initial begin
    int at, c, t0, n;
    rst_n = 1'b0; req_a = '0; req_b = '0;
    m_cs = '1; m_mosi = '1; m_sclk = '0; miso = 1'b0;
    tick(2);
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_to", 32'(to_a), 0);
    chk("rst_pins", 32'({cs_a, mosi_a, sclk_a}), 32'b110);
    chk("rst_idx", 32'(gidx_a), 0);
    chk("rst_b", 32'({grant_b, busy_b, cs_b}), 32'b00001);
    miso = 1'b1; #1;
    chk("miso_fan", 32'({mmiso_a, mmiso_b}), 32'b11);
    miso = 1'b0;
    rst_n = 1'b1;
    tick(1);

    // round-robin rotation with everyone requesting
    req_a = '1;
    sb.push_back('{g: oh(0), at: cyc + 10});
    for (int k = 0; k < 5; k++) begin
      wait_gnt(1'b0, at);
      tick(20);
      req_a[k % N] = 1'b0;
      if (k < 4) sb.push_back('{g: oh((k + 1) % N), at: cyc + 11});
      tick(1);
      if (k < 4) req_a[k % N] = 1'b1;
      else req_a = '0;
    end
    tick(3);

    // guard timing, pin routing, unselected masters ignored
    m_cs = 4'b1011; m_mosi = 4'b1011; m_sclk = 4'b0001;
    req_a = 4'b0100;
    c = cyc;
    sb.push_back('{g: oh(2), at: c + 10});
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t1_cs_guard", 32'(cs_a), 1);
    end
    chk("t1_busy", 32'(busy_a), 1);
    tick(1);
    chk("t1_pins", 32'({cs_a, mosi_a, sclk_a}), 32'b000);
    m_sclk = 4'b0100;
    tick(1);
    chk("t1_sclk", 32'(sclk_a), 1);
    req_a = '0;
    tick(1);
    chk("t1_rel", 32'({grant_a, busy_a, cs_a, mosi_a, sclk_a}), 32'b0000_0_110);
    m_cs = '1; m_mosi = '1; m_sclk = '0;
    tick(3);

    // hold timeout and lockout
    t0 = to_cnt;
    req_a = 4'b0010;
    sb.push_back('{g: oh(1), at: cyc + 10});
    wait_gnt(1'b0, at);
    n = 0;
    while (grant_a[1] && n < 200) begin
      tick(1);
      n++;
    end
    chk("t4_hold", n, 100);
    tick(2);
    chk("t4_to", to_cnt - t0, 1);
    tick(20);
    chk("t4_lock", 32'({grant_a, busy_a}), 0);
    req_a[1] = 1'b0;
    tick(1);
    req_a[1] = 1'b1;
    sb.push_back('{g: oh(1), at: cyc + 10});
    wait_gnt(1'b0, at);
    tick(5);
    req_a = '0;
    tick(3);

    // request withdrawn during guard
    m_cs = 4'b0111;
    req_a = 4'b1000;
    tick(4);
    req_a = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t5_idle", 32'({grant_a, busy_a, cs_a}), 32'b00001);
    end
    m_cs = '1;
    req_a = 4'b1000;
    sb.push_back('{g: oh(3), at: cyc + 10});
    wait_gnt(1'b0, at);
    req_a = '0;
    tick(3);

    // reset mid-transfer
    req_a = 4'b0100;
    sb.push_back('{g: oh(2), at: cyc + 10});
    wait_gnt(1'b0, at);
    m_cs = 4'b1011; m_mosi = 4'b1011; m_sclk = 4'b0100;
    tick(2);
    chk("t6_cs_low", 32'(cs_a), 0);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst", 32'({grant_a, busy_a, cs_a, mosi_a, sclk_a}), 32'b0000_0_110);
    rst_n = 1'b1;
    sb.push_back('{g: oh(2), at: cyc + 10});
    wait_gnt(1'b0, at);
    req_a = '0; m_cs = '1; m_mosi = '1; m_sclk = '0;
    tick(3);

    // fixed priority on instance B
    req_b = '1;
    c = cyc;
    wait_gnt(1'b1, at);
    chk("b_first", 32'(grant_b), 32'(oh(0)));
    chk("b_at", at, c + 10);
    tick(20);
    req_b[0] = 1'b0;
    tick(1);
    req_b[0] = 1'b1;
    wait_gnt(1'b1, at);
    chk("b_regain", 32'(grant_b), 32'(oh(0)));
    tick(5);
    req_b[0] = 1'b0;
    tick(1);
    wait_gnt(1'b1, at);
    chk("b_next", 32'(grant_b), 32'(oh(1)));
    tick(5);
    req_b[0] = 1'b1;
    tick(5);
    chk("b_nopreempt", 32'(grant_b), 32'(oh(1)));
    req_b[1] = 1'b0;
    tick(1);
    wait_gnt(1'b1, at);
    chk("b_back0", 32'(grant_b), 32'(oh(0)));
    req_b = '0;
    tick(3);

    chk("sb_empty", sb.size(), 0);
    chk("to_total", to_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
